ysyx_23060203_csu: RTL and testbench
====================================

Name: ysyx_23060203_csu

Overview:
Control/speculation unit: the receiving end of the WBU's cs_flush/cs_dnpc redirect interface, plus the EXU branch-redirect interface. Owns the architectural fetch PC and issues sequential fetch requests to the IFU. On a redirect it retargets fetch, kills younger pipeline stages and marks in-flight IFU responses for discard. Sits between WBU/EXU (redirect sources) and IFU (fetch sink).

Parameters:
RESET_PC, 32'h3000_0000, first fetch address after reset
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered IFU requests (>=1)

Ports:
clock  input  1  single clock
reset  input  1  synchronous, active-low reset (0 = reset)
wb_flush  input  1  WBU redirect (csr write / exception / mret / fence.i)
wb_dnpc  input  32  WBU redirect target
ex_redirect  input  1  EXU branch/jump mispredict
ex_dnpc  input  32  EXU redirect target
ifu_req_valid  output  1  fetch request valid
ifu_req_ready  input  1  IFU accepts request
ifu_req_pc  output  32  fetch address
ifu_rsp_valid  input  1  IFU returns one response (one per accepted request, in order)
ifu_rsp_kill  output  1  current response is stale; IFU must drop it
flush_front  output  1  kill IFU buffer and IDU contents
flush_back  output  1  kill EXU contents (asserted only for WBU redirect)

Behaviour:
- Reset (reset==0 at posedge): pc<=RESET_PC, outstanding<=0, discard<=0, state<=RUN. While reset==0, ifu_req_valid=0; ifu_rsp_kill, flush_front and flush_back are 0.
- Counters are $clog2(MAX_OUTSTANDING+1) bits wide. Invariant: discard <= outstanding <= MAX_OUTSTANDING.
- Redirect selection, combinational: wb_flush has priority over ex_redirect. redir = wb_flush | ex_redirect. tgt = wb_dnpc if wb_flush, else ex_dnpc.
- flush_front = redir. flush_back = wb_flush. Both are same-cycle combinational with no registering.
- ifu_req_pc = pc. ifu_req_valid = (state==RUN) & (outstanding < MAX_OUTSTANDING). ifu_req_valid does not depend on redir, so there is no comb path from flush inputs to valid.
- acc = ifu_req_valid & ifu_req_ready. rsp = ifu_rsp_valid & (outstanding != 0). A response with outstanding==0 is a protocol error: it is ignored, counters do not underflow, and kill=0.
- ifu_rsp_kill = ifu_rsp_valid & (discard != 0).
- outstanding_next = outstanding + acc - rsp.
- No redirect:
  - pc <= pc+4 on acc (32-bit wrap, 32'hFFFF_FFFC -> 0).
  - discard <= discard - (rsp & discard!=0).
- Redirect cycle:
  - pc <= tgt. pc+4 is suppressed even if acc.
  - discard <= outstanding_next, i.e. every request still in flight, including one accepted this cycle, is stale. This also covers a response arriving this cycle: it is kill-marked only if discard was already nonzero, otherwise it is delivered, because it is older than the redirecting instruction.
  - state <= DRAIN if outstanding_next != 0, else RUN.
- FSM:
  - RUN: issues requests. A redirect transitions as above.
  - DRAIN: ifu_req_valid=0. Each response is killed and decrements discard and outstanding. When discard reaches 0 (the same posedge as the last stale rsp), state <= RUN and the next cycle issues at the redirected pc.
  - A redirect in DRAIN updates pc only; discard stays equal to outstanding.
- Back-to-back redirects: the last one wins; each asserts flush outputs in its own cycle.
- Reset mid-DRAIN: all state cleared immediately. The IFU is reset in the same cycle, so no stale accounting is kept.

Test Plan:
- Reset release with RESET_PC default, ifu_req_ready=1, rsp 1 cycle after accept -> requests at 0x3000_0000, 0x3000_0004, 0x3000_0008 on consecutive cycles; ifu_rsp_kill never 1.
- ifu_req_ready=1, no responses -> exactly 2 accepts (0x3000_0000, 0x3000_0004), then ifu_req_valid=0 until a rsp arrives.
- 2 outstanding, ex_redirect=1 with ex_dnpc=0x3000_0100 -> flush_front=1, flush_back=0 that cycle; valid=0 in DRAIN; next 2 responses have kill=1; next request pc=0x3000_0100.
- wb_flush=1 (wb_dnpc=0x3000_0200) and ex_redirect=1 (ex_dnpc=0x3000_0100) same cycle -> flush_front=flush_back=1; next issued pc=0x3000_0200.
- Redirect coincident with an accept and a non-stale rsp at outstanding=1 -> that rsp kill=0, discard=1; exactly one later rsp killed; then fetch at the target.
- reset=0 asserted during DRAIN with discard=2, held 1 cycle -> outputs idle; after release, first request at RESET_PC; no kills.

Source files
------------

// File: rtl/ysyx_23060203_csu.sv
`default_nettype none
// ============================================================================
// ysyx_23060203_csu : fetch-PC owner and redirect/stale-response controller
// Revision: 1.0
// ============================================================================
module ysyx_23060203_csu #(
    parameter logic [31:0] RESET_PC        = 32'h3000_0000,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_flush,
    input  logic [31:0] wb_dnpc,
    input  logic        ex_redirect,
    input  logic [31:0] ex_dnpc,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    output logic [31:0] ifu_req_pc,
    input  logic        ifu_rsp_valid,
    output logic        ifu_rsp_kill,
    output logic        flush_front,
    output logic        flush_back
);

    localparam int            CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t        state, state_next;
    logic [31:0]   pc, pc_next;
    logic [CW-1:0] outstanding, outstanding_next;
    logic [CW-1:0] discard, discard_next;
    logic          redir;
    logic [31:0]   tgt;
    logic          acc;
    logic          rsp;

    assign redir = wb_flush | ex_redirect;
    assign tgt   = wb_flush ? wb_dnpc : ex_dnpc;

    // All outputs are held idle while reset is asserted.
    assign flush_front   = reset & redir;
    assign flush_back    = reset & wb_flush;
    assign ifu_req_pc    = pc;
    assign ifu_req_valid = reset & (state == RUN) & (outstanding < MAX_CNT);
    assign ifu_rsp_kill  = reset & ifu_rsp_valid & (discard != '0);

    assign acc = ifu_req_valid & ifu_req_ready;
    // A response with nothing outstanding is ignored so counters cannot underflow.
    assign rsp = ifu_rsp_valid & (outstanding != '0);

    always_comb begin
        outstanding_next = outstanding + CW'(acc) - CW'(rsp);
        pc_next          = pc;
        discard_next     = discard;
        state_next       = state;
        if (redir) begin
            // Everything still in flight (including this cycle's accept) is stale.
            pc_next      = tgt;
            discard_next = outstanding_next;
            state_next   = (outstanding_next != '0) ? DRAIN : RUN;
        end else begin
            if (acc) begin
                pc_next = pc + 32'd4;
            end
            if (rsp && (discard != '0)) begin
                discard_next = discard - CW'(1);
            end
            if ((state == DRAIN) && (discard_next == '0)) begin
                state_next = RUN;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            state       <= RUN;
        end else begin
            pc          <= pc_next;
            outstanding <= outstanding_next;
            discard     <= discard_next;
            state       <= state_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060203_csu.sv
`default_nettype none
// ============================================================================
// tb_ysyx_23060203_csu : cycle-vector bench with a fetch-PC scoreboard
// Revision: 1.0
// ============================================================================
module tb_ysyx_23060203_csu;

    logic        clock = 1'b0;
    logic        reset;
    logic        wb_flush;
    logic [31:0] wb_dnpc;
    logic        ex_redirect;
    logic [31:0] ex_dnpc;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_pc;
    logic        ifu_rsp_valid;
    logic        ifu_rsp_kill;
    logic        flush_front;
    logic        flush_back;

    ysyx_23060203_csu dut (
        .clock         (clock),
        .reset         (reset),
        .wb_flush      (wb_flush),
        .wb_dnpc       (wb_dnpc),
        .ex_redirect   (ex_redirect),
        .ex_dnpc       (ex_dnpc),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_pc    (ifu_req_pc),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_kill  (ifu_rsp_kill),
        .flush_front   (flush_front),
        .flush_back    (flush_back)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        wf;
        logic [31:0] wd;
        logic        er;
        logic [31:0] ed;
        logic        rdy;
        logic        rv;
        logic        ev;
        logic [31:0] epc;
        logic        ek;
        logic        eff;
        logic        efb;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] pc_q[$];
    int          checks   = 0;
    int          failures = 0;

    task automatic row(input logic rst, input logic wf, input logic [31:0] wd,
                       input logic er, input logic [31:0] ed,
                       input logic rdy, input logic rv,
                       input logic ev, input logic [31:0] epc,
                       input logic ek, input logic eff, input logic efb);
        vec_t v;
        v.rst = rst; v.wf = wf; v.wd = wd; v.er = er; v.ed = ed;
        v.rdy = rdy; v.rv = rv; v.ev = ev; v.epc = epc;
        v.ek = ek; v.eff = eff; v.efb = efb;
        vecs.push_back(v);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // Pops the expected fetch address whenever the DUT hands off a request.
    task automatic sb_accept(input int idx);
        logic [31:0] exp_pc;
        if (ifu_req_valid && ifu_req_ready) begin
            checks++;
            if (pc_q.size() == 0) begin
                failures++;
                $display("FAIL sb_pc[%0d]: unexpected accept pc=%h expected none", idx, ifu_req_pc);
            end else begin
                exp_pc = pc_q.pop_front();
                if (ifu_req_pc !== exp_pc) begin
                    failures++;
                    $display("FAIL sb_pc[%0d]: got %h expected %h", idx, ifu_req_pc, exp_pc);
                end
            end
        end
    endtask

    task automatic drive_idle();
        reset = 1'b1; wb_flush = 1'b0; wb_dnpc = '0; ex_redirect = 1'b0; ex_dnpc = '0;
        ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0;
    endtask

    initial begin
        int accepts;
        int budget;
        drive_idle();
        reset = 1'b0;

        // rst wf wd er ed rdy rv | ev epc ek ff fb
        row(0,0,0,0,0,1,0, 0,0,0,0,0);
        row(0,0,0,0,0,1,0, 0,0,0,0,0);
        // sequential fetch, one response per accept
        row(1,0,0,0,0,1,0, 1,32'h3000_0000,0,0,0);
        row(1,0,0,0,0,1,1, 1,32'h3000_0004,0,0,0);
        row(1,0,0,0,0,1,1, 1,32'h3000_0008,0,0,0);
        row(1,0,0,0,0,0,1, 1,32'h3000_000C,0,0,0);
        // no responses: two accepts then stall
        row(1,0,0,0,0,1,0, 1,32'h3000_000C,0,0,0);
        row(1,0,0,0,0,1,0, 1,32'h3000_0010,0,0,0);
        row(1,0,0,0,0,1,0, 0,0,0,0,0);
        row(1,0,0,0,0,1,0, 0,0,0,0,0);
        // ex redirect with 2 outstanding, drain, refetch at target
        row(1,0,0,1,32'h3000_0100,1,0, 0,0,0,1,0);
        row(1,0,0,0,0,1,0, 0,0,0,0,0);
        row(1,0,0,0,0,1,1, 0,0,1,0,0);
        row(1,0,0,0,0,1,1, 0,0,1,0,0);
        row(1,0,0,0,0,1,0, 1,32'h3000_0100,0,0,0);
        row(1,0,0,0,0,0,1, 1,0,0,0,0);
        // wb and ex together: wb wins
        row(1,1,32'h3000_0200,1,32'h3000_0100,0,0, 1,0,0,1,1);
        row(1,0,0,0,0,1,0, 1,32'h3000_0200,0,0,0);
        // redirect coincident with accept and an older response
        row(1,0,0,1,32'h3000_0300,1,1, 1,32'h3000_0204,0,1,0);
        row(1,0,0,0,0,1,0, 0,0,0,0,0);
        row(1,0,0,0,0,1,1, 0,0,1,0,0);
        row(1,0,0,0,0,1,0, 1,32'h3000_0300,0,0,0);
        // reset asserted mid-drain with discard=2
        row(1,0,0,0,0,1,0, 1,32'h3000_0304,0,0,0);
        row(1,0,0,1,32'h3000_0400,1,0, 0,0,0,1,0);
        row(0,0,0,1,32'h3000_0500,1,1, 0,0,0,0,0);
        row(1,0,0,0,0,1,0, 1,32'h3000_0000,0,0,0);
        row(1,0,0,0,0,0,1, 1,0,0,0,0);
        // back-to-back redirects, last wins
        row(1,0,0,1,32'h3000_0600,0,0, 1,0,0,1,0);
        row(1,1,32'h3000_0700,0,0,0,0, 1,0,0,1,1);
        row(1,0,0,0,0,1,0, 1,32'h3000_0700,0,0,0);
        row(1,0,0,0,0,0,1, 1,0,0,0,0);
        // stray response with nothing outstanding: no underflow, no kill
        row(1,0,0,0,0,0,1, 1,0,0,0,0);
        row(1,0,0,0,0,1,0, 1,32'h3000_0704,0,0,0);
        row(1,0,0,0,0,0,1, 1,0,0,0,0);
        // PC wraps at the top of the address space
        row(1,0,0,1,32'hFFFF_FFFC,0,0, 1,0,0,1,0);
        row(1,0,0,0,0,1,0, 1,32'hFFFF_FFFC,0,0,0);
        row(1,0,0,0,0,1,1, 1,32'h0000_0000,0,0,0);
        row(1,0,0,0,0,0,1, 1,0,0,0,0);

        foreach (vecs[i]) begin
            @(negedge clock);
            reset = vecs[i].rst; wb_flush = vecs[i].wf; wb_dnpc = vecs[i].wd;
            ex_redirect = vecs[i].er; ex_dnpc = vecs[i].ed;
            ifu_req_ready = vecs[i].rdy; ifu_rsp_valid = vecs[i].rv;
            if (vecs[i].rdy && vecs[i].ev) pc_q.push_back(vecs[i].epc);
            #1;
            check1($sformatf("valid[%0d]", i), ifu_req_valid, vecs[i].ev);
            check1($sformatf("kill[%0d]", i), ifu_rsp_kill, vecs[i].ek);
            check1($sformatf("flush_front[%0d]", i), flush_front, vecs[i].eff);
            check1($sformatf("flush_back[%0d]", i), flush_back, vecs[i].efb);
            sb_accept(i);
        end

        // Stall bound: from empty, ready held high must yield exactly two accepts.
        @(negedge clock);
        drive_idle();
        ifu_req_ready = 1'b1;
        pc_q.push_back(32'h0000_0004);
        pc_q.push_back(32'h0000_0008);
        accepts = 0;
        for (budget = 0; budget < 6; budget++) begin
            #1;
            if (ifu_req_valid) accepts++;
            sb_accept(100 + budget);
            @(negedge clock);
        end
        checks++;
        if (accepts != 2) begin
            failures++;
            $display("FAIL stall_accepts: got %0d expected 2", accepts);
        end

        // One response re-opens exactly one slot within a bounded wait.
        ifu_rsp_valid = 1'b1;
        #1;
        check1("stall_kill", ifu_rsp_kill, 1'b0);
        @(negedge clock);
        ifu_rsp_valid = 1'b0;
        pc_q.push_back(32'h0000_000C);
        budget = 0;
        #1;
        while (!ifu_req_valid && budget < 10) begin
            @(negedge clock);
            #1;
            budget++;
        end
        check1("reopen_valid", ifu_req_valid, 1'b1);
        sb_accept(200);

        checks++;
        if (pc_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d leftover expected 0", pc_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
